// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipeline; the fetch stage adds its FSM state and buffer entry.
// Latency: none (types only); backpressure: n/a.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic {
    FETCH,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } if_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Generic in-order FIFO with flush; head is a registered entry, visible the cycle after push.
// Latency: 1 cycle push-to-head; backpressure: caller must not push when full (flush overrides push/pop).
module fetch_buffer
  import rv32i_types::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = if_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     din,
  output logic [$clog2(DEPTH):0]     count,
  output entry_t                     head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: single-outstanding imem reads into an in-order buffer, head split into decode fields.
// Latency: imem_resp to if_valid 1 cycle; backpressure: stall holds the head, a full buffer blocks new requests.
module fetch_stage
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h0000_0060,
  parameter int        DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output rv32i_opcode if_opcode,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7,
  output logic [4:0]  if_rd,
  output logic [4:0]  if_rs1,
  output logic [4:0]  if_rs2
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic          pending;
  rv32i_word     fetch_pc;
  rv32i_word     target;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          push;
  logic          pop;
  if_entry_t     head;
  if_entry_t     din;

  assign target = redirect_pc & 32'hFFFF_FFFC;

  // Redirect wins over everything: no push of the in-flight word, no pop of the head.
  assign push        = (state == FETCH) && pending && imem_resp && !redirect;
  assign pop         = if_valid && !stall && !redirect;
  assign count_after = count + CW'(push) - CW'(pop);
  assign din         = '{pc: fetch_pc, instr: imem_rdata};

  fetch_buffer #(
    .DEPTH   (DEPTH),
    .entry_t (if_entry_t)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // pending doubles as the registered imem_read; a new request is decided on the same edge
  // that retires the previous one, using the post-edge occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pending      <= 1'b0;
      fetch_pc     <= RESET_PC;
      imem_address <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
      if (pending && !imem_resp) begin
        state <= DISCARD;
      end else begin
        state        <= FETCH;
        pending      <= 1'b1;
        imem_address <= target;
      end
    end else if (state == FETCH) begin
      if (pending) begin
        if (imem_resp) begin
          fetch_pc     <= fetch_pc + 32'd4;
          imem_address <= fetch_pc + 32'd4;
          pending      <= (count_after < CW'(DEPTH));
        end
      end else if (count_after < CW'(DEPTH)) begin
        pending      <= 1'b1;
        imem_address <= fetch_pc;
      end
    end else begin
      if (imem_resp) begin
        state        <= FETCH;
        pending      <= 1'b1;
        imem_address <= fetch_pc;
      end
    end
  end

  assign imem_read = pending;

  assign if_valid  = (count != '0);
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;
  assign if_opcode = rv32i_opcode'(head.instr[6:0]);
  assign if_funct3 = head.instr[14:12];
  assign if_funct7 = head.instr[31:25];
  assign if_rd     = head.instr[11:7];
  assign if_rs1    = head.instr[19:15];
  assign if_rs2    = head.instr[24:20];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. It owns the fetch PC and talks to instruction memory with a single outstanding read. Returned instructions go into a small in-order buffer, and the head entry is presented to decode, split into the opcode/funct3/funct7/rd/rs1/rs2 fields that the control-word generator consumes. Branch/jump redirects from execute flush the buffer and restart fetch, including while a memory read is still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0060, first fetch address after reset
- DEPTH, 2, instruction buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- imem_read  out  1  read request; held until imem_resp
- imem_address  out  32  fetch address; stable while imem_read=1
- imem_resp  in  1  one-cycle read-done pulse
- imem_rdata  in  32  instruction; valid when imem_resp=1
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00)
- stall  in  1  decode cannot accept the head entry this cycle
- if_valid  out  1  head entry present
- if_pc  out  32  PC of head entry
- if_instr  out  32  head instruction word
- if_opcode  out  7  if_instr[6:0], type rv32i_opcode
- if_funct3  out  3  if_instr[14:12]
- if_funct7  out  7  if_instr[31:25]
- if_rd / if_rs1 / if_rs2  out  5 each  if_instr[11:7] / [19:15] / [24:20]

## Operation
- Registers:
  - fetch_pc (next address to request)
  - FSM state: FETCH or DISCARD
  - pending flag (request outstanding)
  - buffer holding {pc, instr} entries, with count in 0..DEPTH
- Issue rule: in FETCH with pending=0, start a request when count + pending < DEPTH. Drive imem_read=1 and imem_address=fetch_pc, then set pending.
- Response in FETCH, no redirect:
  - push {fetch_pc, imem_rdata}
  - fetch_pc += 4 (wraps mod 2^32)
  - clear pending
- Pop: the head is consumed on any cycle with if_valid=1 && stall=0. Push and pop in the same cycle leave count unchanged.
- Redirect. It has priority over pop, push and stall, and in all cases the buffer is flushed (count=0) and fetch_pc is set to {redirect_pc[31:2],2'b00}:
  - If pending=0 or imem_resp=1 this cycle: stay in FETCH; the response, if any, is dropped.
  - If pending=1 and imem_resp=0: go to DISCARD. Keep imem_read and imem_address unchanged; the memory protocol forbids abandoning a read.
- DISCARD:
  - on imem_resp: drop the data, clear pending, return to FETCH
  - no pushes occur
  - a further redirect only overwrites fetch_pc
- Buffer full: no new request is issued; the outstanding request still completes and has a reserved slot.
- Decode fields are a combinational slice of the head instr. They are don't-care when if_valid=0.

## Timing
- Reset (rst_n=0):
  - imem_read=0, imem_address=RESET_PC
  - if_valid=0, if_pc=0, if_instr=0 (fields 0)
  - fetch_pc=RESET_PC, state FETCH, pending=0, count=0
  - Reset in the middle of a request abandons it; the memory side is reset by the same rst_n.
- First cycle after rst_n deasserts: imem_read=1, imem_address=RESET_PC.
- imem_resp in cycle N:
  - entry is visible on if_valid/if_pc/if_instr in cycle N+1
  - no combinational bypass from imem_rdata
- Back-to-back requests: a new request can be asserted in cycle N+1 at fetch_pc+4. With single-cycle memory and stall=0, the stage sustains one instruction every 2 cycles.
- Redirect in cycle N:
  - if_valid=0 in N+1
  - if not entering DISCARD, request to the target is asserted in N+1
  - if entering DISCARD, the target is requested the cycle after the discarded imem_resp
- stall=1 holds all if_* outputs stable.

## Structure
- rv32i_types package:
  - add fetch_state_t enum {FETCH, DISCARD}
  - add the if-stage entry struct {rv32i_word pc; rv32i_word instr}
  - reuse rv32i_word and rv32i_opcode
- Sub-module fetch_buffer:
  - parameterized synchronous FIFO of DEPTH entries
  - inputs push, pop, flush
  - outputs count, head
  - flush overrides push/pop
  - async active-low reset

## Test plan
1. Reset release with 1-cycle memory, stall=0 → requests at 0x60, 0x64, 0x68. if_valid rises 1 cycle after each resp, carrying the matching if_pc and if_instr. For instr 0x00A00093: opcode 0x13, rd=1, rs1=0, funct3=0.
2. stall=1 held for 10 cycles → count reaches 2, imem_read stays 0 with no further requests, if_* outputs are stable. Releasing stall drains entries in PC order with no loss or duplication.
3. Redirect to 0x200 while a read to 0x64 is outstanding (resp 3 cycles later) → imem_address stays 0x64 until resp, the 0x64 data is never valid at the output, and the next request is to 0x200.
4. Redirect and imem_resp in the same cycle → data dropped, buffer empty next cycle, request to the target on the next cycle.
5. Redirect to 0x103 → fetch address 0x100.
6. Redirect with a full buffer and stall=1 → if_valid=0 on the next cycle.
7. Assert rst_n=0 mid-request → all outputs reach their reset values immediately (asynchronously), and fetch restarts at RESET_PC after release.
